mtr_duty_sched: RTL
===================

// Module: mtr_duty_sched
// PURPOSE
//  Sequences the 11-bit duty and H-bridge direction enables for one motor's PWM11 instance.
//  - Accepts signed speed commands over a valid/ready handshake.
//  - Slew-limits the duty and updates it only on PWM period boundaries.
//  - On a direction reversal: ramps to zero, then holds a dead-time before driving the opposite leg.
//  - Sits between the balance controller and the PWM/H-bridge; one instance per wheel.
// PARAMETERS
//  STEP      default 11'd16     max duty change per PWM period (1..2047)
//  MAX_DUTY  default 11'd2000   duty ceiling; |cmd| is clamped to this
//  DEAD_PRDS default 4          whole PWM periods with both enables low on reversal (1..15)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous, active-high reset
//  prd_strt  in   1   1-cycle pulse, PWM counter wrapped to 0 (period boundary)
//  en        in   1   drive enable; low = ramp down to 0, then coast
//  cmd       in  12   signed speed command (two's complement)
//  cmd_vld   in   1   cmd valid
//  cmd_rdy   out  1   block accepts cmd this cycle
//  duty      out 11   duty to PWM11
//  fwd_en    out  1   forward leg enable
//  rev_en    out  1   reverse leg enable (never high together with fwd_en)
//  busy      out  1   high in BRAKE or DEAD
// BEHAVIOUR
//  - Reset (async): state=IDLE, duty=0, fwd_en=0, rev_en=0, cmd_rdy=1, busy=0; target=0, dir=fwd.
//  - Accept = cmd_vld & cmd_rdy (sampled at posedge).
//  - cmd_rdy = 1 in IDLE/RUN and 0 in BRAKE/DEAD; commands offered then are stalled, not dropped.
//  - Magnitude: |cmd| in 12 bits; -2048 saturates to 2047; then min(., MAX_DUTY).
//  - Sign: cmd<0 means reverse. A cmd of 0 sets target=0 and keeps the current dir.
//  - Ramp: only on the cycle after prd_strt. duty moves toward target by at most STEP.
//    - Up: min(duty+STEP, target). Down: max(duty-STEP, target).
//    - Compute in 12 bits; no wrap.
//  - A target accepted in the same cycle as prd_strt first affects the next boundary.
//  - States:
//    - IDLE: duty=0, both enables low. Accept with en=1 and nonzero magnitude -> RUN.
//      dir and target are latched; the enable for dir rises the next cycle; duty ramps from 0.
//      Accept of 0, or with en=0: target latched, stay in IDLE.
//    - RUN: enable for dir high. Accept with the same sign, or of 0: update target only.
//      Accept with the opposite sign: latch pend_tgt/pend_dir.
//      - If duty>0 -> BRAKE.
//      - If duty==0 -> DEAD directly.
//      en low: effective target=0. When duty==0 at a boundary with en low -> IDLE.
//    - BRAKE: target forced to 0; enable stays high.
//      At the boundary where duty reaches 0 -> DEAD; both enables drop the next cycle.
//    - DEAD: both enables low, duty=0. Count DEAD_PRDS prd_strt pulses.
//      On the last pulse: dir=pend_dir, target=pend_tgt -> RUN if en, else IDLE.
//  - en falling in BRAKE/DEAD does not abort the sequence; DEAD exits to IDLE.
//  - fwd_en/rev_en are registered; they never toggle directly from one leg to the other.
//  - Mid-operation reset forces the reset values immediately (async), regardless of state.
// STRUCTURE
//  - Package mtr_pkg: typedef enum logic [1:0] {IDLE,RUN,BRAKE,DEAD} mtr_state_t; DUTY_W=11; CMD_W=12.
//  - Sub-module duty_slew: combinational next-duty from (duty, target, STEP).
//  - Remaining logic (FSM, handshake, dead-time counter, cmd magnitude/clamp) stays in mtr_duty_sched.
// TESTING
//  - Rise: en=1, cmd=+100, STEP=16.
//    -> fwd_en=1 a cycle after accept; duty=16,32,...,96,100 on successive boundaries; rev_en=0 throughout.
//  - Reversal: steady duty=64 fwd, cmd=-48.
//    -> cmd_rdy=0, busy=1; duty 48,32,16,0; both enables low for 4 periods;
//       then rev_en=1 and duty ramps to 48; cmd_rdy returns to 1.
//  - Clamp/saturate: cmd=-2048 and cmd=+2047 with MAX_DUTY=2000 -> target=2000; duty never exceeds 2000.
//  - en drop: duty=40, en->0 -> duty 24,8,0, then IDLE with both enables low.
//    A later cmd=+10 with en=1 re-enters RUN.
//  - Boundary race: cmd accepted on the same cycle as prd_strt -> that boundary uses the old target.
//    Also check: stalled cmd_vld during DEAD is accepted once RUN is entered.
//  - Reset mid-BRAKE: assert rst asynchronously -> duty=0, fwd_en=rev_en=0, cmd_rdy=1 without waiting for clk.
//  - Assertion across all tests: !(fwd_en && rev_en).

Source files
------------

// File: rtl/mtr_duty_sched_pkg.sv
// Shared types and helpers for the motor duty scheduler.
//   mtr_state_t : scheduler FSM state (IDLE, RUN, BRAKE, DEAD)
//   DUTY_W      : PWM duty width (11)
//   CMD_W       : signed speed command width (12)
//   cmd_mag()   : |cmd| saturated to 11 bits, then clamped to a ceiling
package mtr_pkg;

   localparam int DUTY_W = 11;
   localparam int CMD_W  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BRAKE = 2'd2,
      DEAD  = 2'd3
   } mtr_state_t;

   // Magnitude of a two's-complement command. -2048 negates to 12'h800,
   // which is the only value with the top bit set; it saturates to 2047.
   function automatic logic [DUTY_W-1:0] cmd_mag(input logic [CMD_W-1:0] cmd,
                                                 input logic [DUTY_W-1:0] max_duty);
      logic [CMD_W-1:0] a;
      a = cmd[CMD_W-1] ? -cmd : cmd;
      if (a[CMD_W-1]) a = {1'b0, {(CMD_W-1){1'b1}}};
      if (a > {1'b0, max_duty}) return max_duty;
      return a[DUTY_W-1:0];
   endfunction

endpackage

// File: rtl/mtr_duty_sched_if.sv
// Bundle between the balance controller / PWM side and mtr_duty_sched.
//   prd_strt : 1-cycle pulse at each PWM period boundary
//   en       : drive enable
//   cmd      : signed speed command, with cmd_vld / cmd_rdy handshake
//   duty     : duty to the PWM
//   fwd_en   : forward leg enable
//   rev_en   : reverse leg enable
//   busy     : reversal sequence in progress
//   state    : scheduler FSM state, for observation
// Handshake: a command transfers on a rising clk edge where cmd_vld and
// cmd_rdy are both high. While cmd_vld is high and cmd_rdy is low the
// offer stalls; the source holds cmd stable until the transfer.
interface mtr_duty_sched_if;
   import mtr_pkg::*;

   logic                     prd_strt;
   logic                     en;
   logic [CMD_W-1:0]         cmd;
   logic                     cmd_vld;
   logic                     cmd_rdy;
   logic [DUTY_W-1:0]        duty;
   logic                     fwd_en;
   logic                     rev_en;
   logic                     busy;
   mtr_state_t               state;

   modport slave (
      input  prd_strt, en, cmd, cmd_vld,
      output cmd_rdy, duty, fwd_en, rev_en, busy, state
   );

   modport master (
      output prd_strt, en, cmd, cmd_vld,
      input  cmd_rdy, duty, fwd_en, rev_en, busy, state
   );

endinterface

// File: rtl/mtr_duty_sched_duty_slew.sv
// Next duty for one PWM period: move from duty_i toward tgt_i by at most
// STEP, never overshooting the target.
//   duty_i     : current duty
//   tgt_i      : target duty
//   duty_nxt_o : duty after one slew step
module duty_slew import mtr_pkg::*; #(
   parameter logic [DUTY_W-1:0] STEP = 11'd16
) (
   input  logic [DUTY_W-1:0] duty_i,
   input  logic [DUTY_W-1:0] tgt_i,
   output logic [DUTY_W-1:0] duty_nxt_o
);

   logic [DUTY_W:0] d_w, t_w, s_w, up_w, dn_w;

   // One extra bit so duty+STEP cannot wrap.
   assign d_w  = {1'b0, duty_i};
   assign t_w  = {1'b0, tgt_i};
   assign s_w  = {1'b0, STEP};
   assign up_w = d_w + s_w;
   assign dn_w = d_w - s_w;

   always_comb begin
      duty_nxt_o = tgt_i;
      if (d_w < t_w) begin
         if (up_w < t_w) duty_nxt_o = up_w[DUTY_W-1:0];
      end else if (d_w > t_w) begin
         // d_w > s_w guards the subtraction against borrowing.
         if ((d_w > s_w) && (dn_w > t_w)) duty_nxt_o = dn_w[DUTY_W-1:0];
      end
   end

endmodule

// File: rtl/mtr_duty_sched.sv
// Duty and H-bridge direction sequencer for one wheel's PWM.
// Accepts signed speed commands, slew-limits the duty on PWM period
// boundaries and inserts a ramp-down plus dead-time on direction reversal.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   mtr_if : command, period strobe, enable and drive outputs (slave side)
module mtr_duty_sched import mtr_pkg::*; #(
   parameter logic [DUTY_W-1:0] STEP      = 11'd16,
   parameter logic [DUTY_W-1:0] MAX_DUTY  = 11'd2000,
   parameter int                DEAD_PRDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   mtr_duty_sched_if.slave    mtr_if
);

   localparam logic [3:0] DEAD_LAST = 4'(DEAD_PRDS - 1);

   mtr_state_t        state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] tgt_q, tgt_d;
   logic [DUTY_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              dir_q, dir_d;          // 0 = forward, 1 = reverse
   logic              pend_dir_q, pend_dir_d;
   logic [3:0]        dead_q, dead_d;
   logic              fwd_q, fwd_d, rev_q, rev_d;

   logic [DUTY_W-1:0] mag, slew_tgt, slew_nxt;
   logic              cmd_neg, acc;

   assign mag     = cmd_mag(mtr_if.cmd, MAX_DUTY);
   assign cmd_neg = mtr_if.cmd[CMD_W-1];

   assign mtr_if.cmd_rdy = (state_q == IDLE) || (state_q == RUN);
   assign acc            = mtr_if.cmd_vld && mtr_if.cmd_rdy;

   // Only RUN with en high chases the stored target; everything else ramps to 0.
   assign slew_tgt = ((state_q == RUN) && mtr_if.en) ? tgt_q : '0;

   duty_slew #(.STEP(STEP)) u_slew (
      .duty_i     (duty_q),
      .tgt_i      (slew_tgt),
      .duty_nxt_o (slew_nxt)
   );

   // Targets written on a prd_strt edge land in tgt_q together with that
   // edge's duty update, so the update still uses the previous target.
   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      tgt_d      = tgt_q;
      dir_d      = dir_q;
      pend_tgt_d = pend_tgt_q;
      pend_dir_d = pend_dir_q;
      dead_d     = dead_q;
      case (state_q)
         IDLE: begin
            duty_d = '0;
            if (acc) begin
               tgt_d = mag;
               if (mag != '0) begin
                  dir_d = cmd_neg;
                  if (mtr_if.en) state_d = RUN;
               end
            end
         end
         RUN: begin
            if (mtr_if.prd_strt) duty_d = slew_nxt;
            if (acc && (mag != '0) && (cmd_neg != dir_q)) begin
               pend_tgt_d = mag;
               pend_dir_d = cmd_neg;
               dead_d     = '0;
               if (duty_q != '0) begin
                  state_d = BRAKE;
               end else begin
                  state_d = DEAD;
                  duty_d  = '0;
               end
            end else begin
               if (acc) tgt_d = mag;
               if (mtr_if.prd_strt && !mtr_if.en && (slew_nxt == '0)) state_d = IDLE;
            end
         end
         BRAKE: begin
            tgt_d = '0;
            if (mtr_if.prd_strt) begin
               duty_d = slew_nxt;
               if (slew_nxt == '0) begin
                  state_d = DEAD;
                  dead_d  = '0;
               end
            end
         end
         DEAD: begin
            duty_d = '0;
            if (mtr_if.prd_strt) begin
               if (dead_q == DEAD_LAST) begin
                  dir_d   = pend_dir_q;
                  tgt_d   = pend_tgt_q;
                  state_d = mtr_if.en ? RUN : IDLE;
               end else begin
                  dead_d = dead_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Enables follow the next state; dir only changes on a DEAD or IDLE
      // exit, so a leg can never hand over directly to the other one.
      fwd_d = ((state_d == RUN) || (state_d == BRAKE)) && !dir_d;
      rev_d = ((state_d == RUN) || (state_d == BRAKE)) &&  dir_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         duty_q     <= '0;
         tgt_q      <= '0;
         dir_q      <= 1'b0;
         pend_tgt_q <= '0;
         pend_dir_q <= 1'b0;
         dead_q     <= '0;
         fwd_q      <= 1'b0;
         rev_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         tgt_q      <= tgt_d;
         dir_q      <= dir_d;
         pend_tgt_q <= pend_tgt_d;
         pend_dir_q <= pend_dir_d;
         dead_q     <= dead_d;
         fwd_q      <= fwd_d;
         rev_q      <= rev_d;
      end
   end

   assign mtr_if.duty   = duty_q;
   assign mtr_if.fwd_en = fwd_q;
   assign mtr_if.rev_en = rev_q;
   assign mtr_if.busy   = (state_q == BRAKE) || (state_q == DEAD);
   assign mtr_if.state  = state_q;

endmodule
